// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one data-memory port between the CPU load/store path
// (port 0) and a loader/debug master (port 1). Round-robin with bounded
// bursts, combinational memory drive from the owner, registered read return.
module dmem_arbiter #(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int MAX_BURST = 4
) (
  input  logic          clk,
  input  logic          reset,
  // port 0: CPU load/store path
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          gnt0,
  output logic          rvalid0,
  output logic [DW-1:0] rdata0,
  // port 1: loader/debug master
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          gnt1,
  output logic          rvalid1,
  output logic [DW-1:0] rdata1,
  // CPU hold-off
  output logic          cpu_stall,
  // memory side
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_read,
  output logic          mem_write,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  // Counter must be able to hold MAX_BURST itself (saturation value).
  localparam int CNT_W = (MAX_BURST < 1) ? 1 : $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);

  state_t           state_q, state_d;
  logic             rr_last_q, rr_last_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic             rvalid0_q, rvalid0_d;
  logic             rvalid1_q, rvalid1_d;
  logic [DW-1:0]    rdata0_q, rdata0_d;
  logic [DW-1:0]    rdata1_q, rdata1_d;

  logic             beat0;
  logic             beat1;
  logic [CNT_W-1:0] cnt_inc;

  assign gnt0      = (state_q == GNT0);
  assign gnt1      = (state_q == GNT1);
  assign beat0     = gnt0 & req0;
  assign beat1     = gnt1 & req1;
  assign cpu_stall = req0 & ~gnt0;
  assign rvalid0   = rvalid0_q;
  assign rvalid1   = rvalid1_q;
  assign rdata0    = rdata0_q;
  assign rdata1    = rdata1_q;

  // Saturating beat count; once at MAX_BURST any further beat still counts as "burst full".
  assign cnt_inc = (beat_cnt_q == CNT_MAX) ? CNT_MAX : beat_cnt_q + CNT_W'(1);

  // Memory drive: owner's address/data, strobes only when the owner is actually requesting.
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    if (gnt0) begin
      mem_addr  = addr0;
      mem_wdata = wdata0;
      mem_read  = req0 & ~we0;
      mem_write = req0 & we0;
    end else if (gnt1) begin
      mem_addr  = addr1;
      mem_wdata = wdata1;
      mem_read  = req1 & ~we1;
      mem_write = req1 & we1;
    end
  end

  // Grant sequencing: round-robin from IDLE, bounded bursts under contention, no idle gap on hand-over.
  always_comb begin
    state_d    = state_q;
    rr_last_d  = rr_last_q;
    beat_cnt_d = beat_cnt_q;
    if (beat0) rr_last_d = 1'b0;
    if (beat1) rr_last_d = 1'b1;
    case (state_q)
      IDLE: begin
        beat_cnt_d = '0;
        if (req0 && req1) state_d = rr_last_q ? GNT0 : GNT1;
        else if (req0)    state_d = GNT0;
        else if (req1)    state_d = GNT1;
      end
      GNT0: begin
        if (!req0) begin
          state_d    = req1 ? GNT1 : IDLE;
          beat_cnt_d = '0;
        end else if (req1 && (cnt_inc == CNT_MAX)) begin
          state_d    = GNT1;
          beat_cnt_d = '0;
        end else begin
          beat_cnt_d = cnt_inc;
        end
      end
      GNT1: begin
        if (!req1) begin
          state_d    = req0 ? GNT0 : IDLE;
          beat_cnt_d = '0;
        end else if (req0 && (cnt_inc == CNT_MAX)) begin
          state_d    = GNT0;
          beat_cnt_d = '0;
        end else begin
          beat_cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d    = IDLE;
        beat_cnt_d = '0;
      end
    endcase
  end

  // Read return: capture memory data on the edge closing a read beat, even if the grant moves there.
  always_comb begin
    rvalid0_d = beat0 & ~we0;
    rvalid1_d = beat1 & ~we1;
    rdata0_d  = rdata0_q;
    rdata1_d  = rdata1_q;
    if (rvalid0_d) rdata0_d = mem_rdata;
    if (rvalid1_d) rdata1_d = mem_rdata;
  end

  // All arbiter state; reset drops any pending response and favours port 0 first.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      rr_last_q  <= 1'b1;
      beat_cnt_q <= '0;
      rvalid0_q  <= 1'b0;
      rvalid1_q  <= 1'b0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
    end else begin
      state_q    <= state_d;
      rr_last_q  <= rr_last_d;
      beat_cnt_q <= beat_cnt_d;
      rvalid0_q  <= rvalid0_d;
      rvalid1_q  <= rvalid1_d;
      rdata0_q   <= rdata0_d;
      rdata1_q   <= rdata1_d;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed checks of the data-memory arbiter with a small
// memory stub (fixed read pattern, write log).
module tb_dmem_arbiter;

  logic        clk;
  logic        reset;
  logic        req0, we0, req1, we1;
  logic [31:0] addr0, wdata0, addr1, wdata1;
  logic        gnt0, rvalid0, gnt1, rvalid1, cpu_stall;
  logic [31:0] rdata0, rdata1;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_read, mem_write;
  logic [31:0] wmem [0:15];

  int checks = 0;
  int errors = 0;

  dmem_arbiter #(.AW(32), .DW(32), .MAX_BURST(4)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
    .cpu_stall(cpu_stall),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Read pattern: 0x10 holds 0xDEADBEEF, every other word reads addr + 0x1000_0000.
  assign mem_rdata = (mem_addr == 32'h10) ? 32'hDEADBEEF : mem_addr + 32'h1000_0000;

  // Write log of the memory stub.
  always @(posedge clk) begin
    if (mem_write) wmem[mem_addr[5:2]] <= mem_wdata;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
    $display("check %s observed=%h expected=%h", tag, obs, exp);
  endtask

  initial begin
    reset = 1'b0;
    req0 = 0; we0 = 0; addr0 = 0; wdata0 = 0;
    req1 = 0; we1 = 0; addr1 = 0; wdata1 = 0;
    repeat (2) tick();
    #3 reset = 1'b1;
    #1;
    // reset state
    chk("rst_gnt0", 32'(gnt0), 32'd0);
    chk("rst_gnt1", 32'(gnt1), 32'd0);
    chk("rst_rvalid0", 32'(rvalid0), 32'd0);
    chk("rst_rvalid1", 32'(rvalid1), 32'd0);
    chk("rst_rdata0", rdata0, 32'd0);
    chk("rst_rdata1", rdata1, 32'd0);
    chk("rst_mem_read", 32'(mem_read), 32'd0);
    chk("rst_mem_write", 32'(mem_write), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);

    // single read from port 0
    req0 = 1; we0 = 0; addr0 = 32'h10;
    #1;
    chk("rd_stall_c0", 32'(cpu_stall), 32'd1);
    chk("rd_gnt0_c0", 32'(gnt0), 32'd0);
    tick();
    chk("rd_gnt0_c1", 32'(gnt0), 32'd1);
    chk("rd_mem_read_c1", 32'(mem_read), 32'd1);
    chk("rd_mem_addr_c1", mem_addr, 32'h10);
    chk("rd_stall_c1", 32'(cpu_stall), 32'd0);
    chk("rd_rvalid0_c1", 32'(rvalid0), 32'd0);
    tick();
    chk("rd_rvalid0_c2", 32'(rvalid0), 32'd1);
    chk("rd_rdata0_c2", rdata0, 32'hDEADBEEF);
    req0 = 0;
    tick();
    chk("rd_rvalid0_c3", 32'(rvalid0), 32'd0);
    chk("rd_rdata0_hold", rdata0, 32'hDEADBEEF);
    chk("rd_gnt0_c3", 32'(gnt0), 32'd0);

    // both ports held from reset release: alternating 4-beat bursts
    reset = 1'b0;
    req0 = 1; we0 = 0; addr0 = 32'h0;
    req1 = 1; we1 = 0; addr1 = 32'h4;
    #1;
    chk("rr_rst_gnt0", 32'(gnt0), 32'd0);
    chk("rr_rst_gnt1", 32'(gnt1), 32'd0);
    chk("rr_rst_mem_read", 32'(mem_read), 32'd0);
    chk("rr_rst_rdata0", rdata0, 32'd0);
    tick();
    #3 reset = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      logic exp_g0;
      tick();
      exp_g0 = (((c - 1) / 4) % 2) == 0;
      chk($sformatf("rr_gnt0_c%0d", c), 32'(gnt0), 32'(exp_g0));
      chk($sformatf("rr_gnt1_c%0d", c), 32'(gnt1), 32'(!exp_g0));
      chk($sformatf("rr_mem_read_c%0d", c), 32'(mem_read), 32'd1);
      chk($sformatf("rr_stall_c%0d", c), 32'(cpu_stall), 32'(!exp_g0));
      if (c == 5) begin
        chk("rr_rvalid0_c5", 32'(rvalid0), 32'd1);
        chk("rr_rdata0_c5", rdata0, 32'h1000_0000);
      end
      if (c == 6) begin
        chk("rr_rvalid1_c6", 32'(rvalid1), 32'd1);
        chk("rr_rdata1_c6", rdata1, 32'h1000_0004);
      end
    end

    // port 1 write-only burst of 6 beats
    reset = 1'b0;
    req0 = 0; req1 = 0;
    #2 reset = 1'b1;
    req1 = 1; we1 = 1; addr1 = 32'h0; wdata1 = 32'h0;
    for (int c = 1; c <= 6; c++) begin
      tick();
      chk($sformatf("wr_gnt1_b%0d", c - 1), 32'(gnt1), 32'd1);
      chk($sformatf("wr_mem_write_b%0d", c - 1), 32'(mem_write), 32'd1);
      chk($sformatf("wr_mem_addr_b%0d", c - 1), mem_addr, 32'((c - 1) * 4));
      chk($sformatf("wr_mem_wdata_b%0d", c - 1), mem_wdata, 32'(c - 1));
      chk($sformatf("wr_rvalid1_b%0d", c - 1), 32'(rvalid1), 32'd0);
      if (c < 6) begin
        addr1 = 32'(c * 4);
        wdata1 = 32'(c);
      end else begin
        req1 = 0;
      end
    end
    tick();
    chk("wr_gnt1_end", 32'(gnt1), 32'd0);
    chk("wr_mem_write_end", 32'(mem_write), 32'd0);
    chk("wr_log2", wmem[2], 32'd2);
    chk("wr_log5", wmem[5], 32'd5);

    // reset asserted mid-burst (GNT1, beat 2)
    req1 = 1; we1 = 0; addr1 = 32'h8;
    tick();
    tick();
    chk("mr_gnt1_b2", 32'(gnt1), 32'd1);
    chk("mr_rvalid1_b2", 32'(rvalid1), 32'd1);
    chk("mr_mem_read_b2", 32'(mem_read), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("mr_gnt1_rst", 32'(gnt1), 32'd0);
    chk("mr_rvalid1_rst", 32'(rvalid1), 32'd0);
    chk("mr_mem_read_rst", 32'(mem_read), 32'd0);
    chk("mr_mem_write_rst", 32'(mem_write), 32'd0);
    chk("mr_rdata1_rst", rdata1, 32'd0);
    tick();
    #2 reset = 1'b1;
    #1;
    chk("mr_idle_after", 32'(gnt1), 32'd0);
    tick();
    chk("mr_first_grant", 32'(gnt1), 32'd1);
    req1 = 0;
    tick();
    chk("mr_idle_end", 32'(gnt1), 32'd0);

    // port 0 drops while port 1 rises mid-burst: immediate hand-over
    req0 = 1; we0 = 0; addr0 = 32'h0;
    tick();
    tick();
    req0 = 0;
    req1 = 1; we1 = 0; addr1 = 32'h4;
    #1;
    chk("ho_gnt0_b2", 32'(gnt0), 32'd1);
    chk("ho_no_strobe", 32'(mem_read), 32'd0);
    chk("ho_stall_b2", 32'(cpu_stall), 32'd0);
    tick();
    chk("ho_gnt1", 32'(gnt1), 32'd1);
    chk("ho_gnt0", 32'(gnt0), 32'd0);
    chk("ho_stall", 32'(cpu_stall), 32'd0);
    chk("ho_mem_read", 32'(mem_read), 32'd1);

    // port 1 owns, CPU waits 3 cycles for its grant
    tick();
    req0 = 1; we0 = 0; addr0 = 32'h10;
    #1;
    chk("st_stall_1", 32'(cpu_stall), 32'd1);
    tick();
    chk("st_stall_2", 32'(cpu_stall), 32'd1);
    chk("st_gnt1_2", 32'(gnt1), 32'd1);
    tick();
    chk("st_stall_3", 32'(cpu_stall), 32'd1);
    chk("st_gnt1_3", 32'(gnt1), 32'd1);
    tick();
    chk("st_gnt0", 32'(gnt0), 32'd1);
    chk("st_gnt1_off", 32'(gnt1), 32'd0);
    chk("st_stall_off", 32'(cpu_stall), 32'd0);
    chk("st_mem_addr", mem_addr, 32'h10);
    req1 = 0;
    tick();
    chk("st_rvalid0", 32'(rvalid0), 32'd1);
    chk("st_rdata0", rdata0, 32'hDEADBEEF);
    req0 = 0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
